// File: rtl/out_port_uart_tx.sv
// Output-port UART transmitter: processor port writes are queued in a small FIFO
// and shifted out as 8N1 frames, LSB first, on a registered serial line.
`timescale 1ns/1ps
module out_port_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] port_data,
   input  logic       port_we,
   input  logic       ovf_clr,
   output logic       tx,
   output logic       busy,
   output logic       fifo_full,
   output logic       fifo_empty,
   output logic       overflow
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned BW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nxt;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [7:0]    shift, shift_nxt;
   logic [2:0]    bit_cnt, bit_cnt_nxt;
   logic [BW-1:0] baud_cnt, baud_cnt_nxt;
   logic          tx_q, tx_nxt, ovf_q;
   logic          pop, push, drop, baud_done;

   // A pop on the same edge frees a slot, so a write while full is still accepted
   assign pop       = (state == IDLE) && (count != '0);
   assign push      = port_we && ((count != FULL_CNT) || pop);
   assign drop      = port_we && !push;
   assign baud_done = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (drop)         ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= port_data;
   end

   // State register, with the shift/count datapath and the registered line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         shift    <= '0;
         bit_cnt  <= '0;
         baud_cnt <= '0;
         tx_q     <= 1'b1;
      end else begin
         state    <= state_nxt;
         shift    <= shift_nxt;
         bit_cnt  <= bit_cnt_nxt;
         baud_cnt <= baud_cnt_nxt;
         tx_q     <= tx_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      shift_nxt    = shift;
      bit_cnt_nxt  = bit_cnt;
      baud_cnt_nxt = baud_done ? '0 : baud_cnt + BW'(1);
      case (state)
         IDLE: begin
            baud_cnt_nxt = '0;
            if (pop) begin
               state_nxt   = START;
               shift_nxt   = mem[rd_ptr];
               bit_cnt_nxt = '0;
            end
         end
         START: if (baud_done) state_nxt = DATA;
         DATA: begin
            if (baud_done) begin
               shift_nxt   = {1'b0, shift[7:1]};
               bit_cnt_nxt = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nxt = STOP;
            end
         end
         STOP: if (baud_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Line level is computed from the next state so tx changes on the same edge as the state
   always_comb begin
      tx_nxt = 1'b1;
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shift_nxt[0];
         default: tx_nxt = 1'b1;
      endcase
   end

   assign tx         = tx_q;
   assign busy       = (state != IDLE);
   assign fifo_full  = (count == FULL_CNT);
   assign fifo_empty = (count == '0);
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Bench for out_port_uart_tx: frame-timer/queue model checked every cycle,
// independent serial decoder, and hand-computed literal expectations.
`timescale 1ns/1ps
module tb_out_port_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       port_we = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [7:0] port_data = 8'h00;
   logic       tx, busy, fifo_full, fifo_empty, overflow;

   int vectors = 0;
   int miscompares = 0;

   out_port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .port_data(port_data), .port_we(port_we),
      .ovf_clr(ovf_clr), .tx(tx), .busy(busy), .fifo_full(fifo_full),
      .fifo_empty(fifo_empty), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: byte queue plus a frame timer counting cycles since the frame started
   logic [7:0] m_q[$];
   bit         m_busy = 1'b0;
   int         m_t = 0;
   logic [7:0] m_byte = 8'h00;
   bit         m_ovf = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_busy = 1'b0;
         m_t    = 0;
         m_byte = 8'h00;
         m_ovf  = 1'b0;
      end else begin
         bit dropped;
         dropped = 1'b0;
         if (m_busy) begin
            m_t++;
            if (m_t == 10*CPB) m_busy = 1'b0;
         end else if (m_q.size() != 0) begin
            m_byte = m_q.pop_front();
            m_busy = 1'b1;
            m_t    = 0;
         end
         if (port_we) begin
            if (m_q.size() < DEPTH) m_q.push_back(port_data);
            else dropped = 1'b1;
         end
         if (dropped)      m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
      end
   end

   function automatic logic exp_tx();
      if (!m_busy)          return 1'b1;
      if (m_t < CPB)        return 1'b0;
      if (m_t < 9*CPB)      return m_byte[m_t/CPB - 1];
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         chk("tx", tx, exp_tx());
         chk("busy", busy, m_busy);
         chk("fifo_full", fifo_full, m_q.size() == DEPTH);
         chk("fifo_empty", fifo_empty, m_q.size() == 0);
         chk("overflow", overflow, m_ovf);
      end
   end

   // Independent serial decoder sampling mid-bit
   logic [7:0] rx_q[$];
   bit         rx_act = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_byte = 8'h00;

   always @(negedge clk) begin
      if (rst) begin
         rx_act = 1'b0;
         rx_cnt = 0;
      end else if (!rx_act) begin
         if (tx == 1'b0) begin
            rx_act  = 1'b1;
            rx_cnt  = 0;
            rx_byte = 8'h00;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt >= CPB + CPB/2 && rx_cnt < 9*CPB && ((rx_cnt - CPB/2) % CPB) == 0)
            rx_byte[(rx_cnt - CPB/2)/CPB - 1] = tx;
         if (rx_cnt == 9*CPB + CPB/2) begin
            chk("stop_bit", tx, 1'b1);
            rx_q.push_back(rx_byte);
         end
         if (rx_cnt == 10*CPB - 1) rx_act = 1'b0;
      end
   end

   task automatic wr(input logic [7:0] b);
      port_data = b;
      port_we   = 1'b1;
      @(negedge clk);
      port_we   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_busy_low(input int max, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk(name, busy, 1'b0);
   endtask

   task automatic wait_done(input int max, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (busy === 1'b0 && fifo_empty === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk(name, {busy, fifo_empty}, 2'b01);
   endtask

   task automatic check_rx(input string name, input int n, input logic [79:0] exp);
      chk({name, "_count"}, rx_q.size(), n);
      for (int i = 0; i < n; i++)
         if (i < rx_q.size()) chk($sformatf("%s_byte%0d", name, i), rx_q[i], exp[8*i +: 8]);
      rx_q.delete();
   endtask

   initial begin
      logic [9:0] frame35;
      frame35 = 10'b1_00110101_0;

      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_empty", fifo_empty, 1'b1);
      chk("rst_full", fifo_full, 1'b0);
      chk("rst_ovf", overflow, 1'b0);

      // Single byte 0x35: literal waveform
      wr(8'h35);
      chk("single_pre_tx", tx, 1'b1);
      chk("single_pre_busy", busy, 1'b0);
      chk("single_pre_empty", fifo_empty, 1'b0);
      for (int c = 0; c < 10*CPB; c++) begin
         @(negedge clk);
         chk($sformatf("single_tx_c%0d", c), tx, frame35[c/CPB]);
         chk($sformatf("single_busy_c%0d", c), busy, 1'b1);
      end
      @(negedge clk);
      chk("single_end_busy", busy, 1'b0);
      chk("single_end_tx", tx, 1'b1);
      check_rx("single", 1, 80'h35);

      // Burst of four back-to-back writes
      wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
      chk("burst_ovf", overflow, 1'b0);
      wait_busy_low(100, "burst_gap_timeout");
      chk("burst_gap_tx", tx, 1'b1);
      chk("burst_gap_empty", fifo_empty, 1'b0);
      @(negedge clk);
      chk("burst_next_busy", busy, 1'b1);
      chk("burst_next_tx", tx, 1'b0);
      wait_done(400, "burst_done_timeout");
      chk("burst_ovf_end", overflow, 1'b0);
      check_rx("burst", 4, 80'h04030201);

      // Overflow: drop while full, then clear
      wr(8'h11); idle(2);
      wr(8'h22); wr(8'h33); wr(8'h44); wr(8'h55);
      chk("ovf_full", fifo_full, 1'b1);
      chk("ovf_pre", overflow, 1'b0);
      wr(8'hFF);
      chk("ovf_set", overflow, 1'b1);
      chk("ovf_still_full", fifo_full, 1'b1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovf_cleared", overflow, 1'b0);
      wait_done(600, "ovf_done_timeout");
      check_rx("ovf", 5, 80'h5544332211);

      // Write on the pop edge while full
      wr(8'hA0); idle(2);
      wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4);
      chk("popedge_full", fifo_full, 1'b1);
      wait_busy_low(100, "popedge_wait_timeout");
      chk("popedge_idle_full", fifo_full, 1'b1);
      wr(8'hA5);
      chk("popedge_count4", fifo_full, 1'b1);
      chk("popedge_ovf", overflow, 1'b0);
      chk("popedge_busy", busy, 1'b1);
      wait_done(800, "popedge_done_timeout");
      check_rx("popedge", 6, 80'hA5A4A3A2A1A0);

      // Pointer wrap with a partly filled FIFO
      for (int i = 0; i < 10; i++) begin
         wr(8'(i));
         idle(29);
      end
      wait_done(600, "wrap_done_timeout");
      chk("wrap_empty", fifo_empty, 1'b1);
      chk("wrap_busy", busy, 1'b0);
      chk("wrap_ovf", overflow, 1'b0);
      check_rx("wrap", 10, 80'h09080706050403020100);

      // Asynchronous reset mid-frame with bytes queued and overflow set
      wr(8'hA5); idle(2);
      wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
      wr(8'hFF);
      chk("mid_ovf_set", overflow, 1'b1);
      idle(6);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_tx", tx, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_empty", fifo_empty, 1'b1);
      chk("mid_rst_full", fifo_full, 1'b0);
      chk("mid_rst_ovf", overflow, 1'b0);
      @(negedge clk);
      #2 rst = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         chk($sformatf("post_rst_tx_c%0d", c), tx, 1'b1);
         chk($sformatf("post_rst_busy_c%0d", c), busy, 1'b0);
      end
      check_rx("post_rst", 0, 80'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
